// File: rtl/lockin_demodulator.sv
// Lock-in demodulator: splits ADC samples into PWM-on/off buckets, blanks settling samples after
// each phase edge, averages 2^AVG_LOG2 samples per bucket and emits on-minus-off with a 1-cycle strobe.
module lockin_demodulator #(
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 4,
    parameter int BLANK      = 2,
    parameter int SIGNED_OUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              phase,
    input  logic              clear,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_on_avg,
    output logic [DATA_W-1:0] out_off_avg,
    output logic [DATA_W:0]   out_diff
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(2 ** AVG_LOG2);

    logic [ACC_W-1:0]  on_acc_q, on_acc_d, off_acc_q, off_acc_d;
    logic [CNT_W-1:0]  on_cnt_q, on_cnt_d, off_cnt_q, off_cnt_d;
    logic              last_phase_q, last_phase_d;
    logic              first_q, first_d;
    logic [3:0]        blank_cnt_q, blank_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_on_avg_q, out_on_avg_d, out_off_avg_q, out_off_avg_d;
    logic [DATA_W:0]   out_diff_q, out_diff_d;

    logic [3:0]        blank_now;
    logic [DATA_W-1:0] on_avg, off_avg;
    logic [DATA_W:0]   diff;

    always_comb begin
        on_acc_d      = on_acc_q;
        off_acc_d     = off_acc_q;
        on_cnt_d      = on_cnt_q;
        off_cnt_d     = off_cnt_q;
        last_phase_d  = last_phase_q;
        first_d       = first_q;
        blank_cnt_d   = blank_cnt_q;
        out_valid_d   = 1'b0;
        out_on_avg_d  = out_on_avg_q;
        out_off_avg_d = out_off_avg_q;
        out_diff_d    = out_diff_q;
        blank_now     = blank_cnt_q;
        on_avg        = '0;
        off_avg       = '0;
        diff          = '0;

        if (clear) begin
            on_acc_d    = '0;
            off_acc_d   = '0;
            on_cnt_d    = '0;
            off_cnt_d   = '0;
            first_d     = 1'b1;
            blank_cnt_d = '0;
        end else if (sample_valid) begin
            // A phase edge (or the first sample after a flush) restarts the settling window,
            // and the edge sample itself is judged against the freshly loaded count.
            if (first_q || (phase != last_phase_q)) begin
                blank_now    = 4'(BLANK);
                last_phase_d = phase;
                first_d      = 1'b0;
            end
            if (blank_now != 4'd0) begin
                blank_cnt_d = blank_now - 4'd1;
            end else begin
                blank_cnt_d = blank_now;
                if (phase) begin
                    if (on_cnt_q < FULL) begin
                        on_acc_d = on_acc_q + ACC_W'(sample);
                        on_cnt_d = on_cnt_q + CNT_W'(1);
                    end
                end else if (off_cnt_q < FULL) begin
                    off_acc_d = off_acc_q + ACC_W'(sample);
                    off_cnt_d = off_cnt_q + CNT_W'(1);
                end
            end

            if ((on_cnt_d == FULL) && (off_cnt_d == FULL)) begin
                on_avg  = DATA_W'(on_acc_d >> AVG_LOG2);
                off_avg = DATA_W'(off_acc_d >> AVG_LOG2);
                diff    = {1'b0, on_avg} - {1'b0, off_avg};
                // Both operands are below 2^DATA_W, so the top bit is the sign of the difference.
                if ((SIGNED_OUT == 0) && diff[DATA_W]) begin
                    diff = '0;
                end
                out_valid_d   = 1'b1;
                out_on_avg_d  = on_avg;
                out_off_avg_d = off_avg;
                out_diff_d    = diff;
                on_acc_d      = '0;
                off_acc_d     = '0;
                on_cnt_d      = '0;
                off_cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_acc_q      <= '0;
            off_acc_q     <= '0;
            on_cnt_q      <= '0;
            off_cnt_q     <= '0;
            last_phase_q  <= 1'b0;
            first_q       <= 1'b1;
            blank_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_on_avg_q  <= '0;
            out_off_avg_q <= '0;
            out_diff_q    <= '0;
        end else begin
            on_acc_q      <= on_acc_d;
            off_acc_q     <= off_acc_d;
            on_cnt_q      <= on_cnt_d;
            off_cnt_q     <= off_cnt_d;
            last_phase_q  <= last_phase_d;
            first_q       <= first_d;
            blank_cnt_q   <= blank_cnt_d;
            out_valid_q   <= out_valid_d;
            out_on_avg_q  <= out_on_avg_d;
            out_off_avg_q <= out_off_avg_d;
            out_diff_q    <= out_diff_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_on_avg  = out_on_avg_q;
    assign out_off_avg = out_off_avg_q;
    assign out_diff    = out_diff_q;
endmodule

// File: tb/tb_lockin_demodulator.sv
// Bench for lockin_demodulator: three instances (BLANK=1 unsigned, BLANK=1 signed, BLANK=0 unsigned)
// share one stimulus stream and are compared against a sum/count reference model.
module tb_lockin_demodulator;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic        phase = 1'b0;
    logic        clear = 1'b0;

    logic        v0, v1, v2;
    logic [11:0] on0, off0, on1, off1, on2, off2;
    logic [12:0] d0, d1, d2;

    int checks = 0;
    int failures = 0;

    // Reference model state; index 0 models BLANK=1, index 1 models BLANK=0.
    int sum_on[2], sum_off[2], n_on[2], n_off[2], blank_left[2];
    bit first[2], last_ph[2];
    bit exp_vld[2];
    int exp_on[2], exp_off[2], exp_du[2], exp_ds[2];
    int pulses0, pulses2;

    lockin_demodulator #(.DATA_W(12), .AVG_LOG2(2), .BLANK(1), .SIGNED_OUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample), .phase(phase),
        .clear(clear), .out_valid(v0), .out_on_avg(on0), .out_off_avg(off0), .out_diff(d0));
    lockin_demodulator #(.DATA_W(12), .AVG_LOG2(2), .BLANK(1), .SIGNED_OUT(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample), .phase(phase),
        .clear(clear), .out_valid(v1), .out_on_avg(on1), .out_off_avg(off1), .out_diff(d1));
    lockin_demodulator #(.DATA_W(12), .AVG_LOG2(2), .BLANK(0), .SIGNED_OUT(0)) u_dut_b0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample), .phase(phase),
        .clear(clear), .out_valid(v2), .out_on_avg(on2), .out_off_avg(off2), .out_diff(d2));

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            sum_on[m] = 0; sum_off[m] = 0; n_on[m] = 0; n_off[m] = 0;
            blank_left[m] = 0; first[m] = 1'b1; last_ph[m] = 1'b0;
            exp_vld[m] = 1'b0; exp_on[m] = 0; exp_off[m] = 0; exp_du[m] = 0; exp_ds[m] = 0;
        end
    endfunction

    function automatic void model_edge(input bit sv, input bit ph, input int s, input bit clr);
        int d;
        for (int m = 0; m < 2; m++) begin
            exp_vld[m] = 1'b0;
            if (clr) begin
                sum_on[m] = 0; sum_off[m] = 0; n_on[m] = 0; n_off[m] = 0;
                first[m] = 1'b1; blank_left[m] = 0;
            end else if (sv) begin
                if (first[m] || ph != last_ph[m]) begin
                    blank_left[m] = (m == 0) ? 1 : 0;
                    last_ph[m] = ph;
                    first[m] = 1'b0;
                end
                if (blank_left[m] > 0) blank_left[m]--;
                else if (ph && n_on[m] < N) begin sum_on[m] += s; n_on[m]++; end
                else if (!ph && n_off[m] < N) begin sum_off[m] += s; n_off[m]++; end
                if (n_on[m] == N && n_off[m] == N) begin
                    exp_vld[m] = 1'b1;
                    exp_on[m] = sum_on[m] / N;
                    exp_off[m] = sum_off[m] / N;
                    d = exp_on[m] - exp_off[m];
                    exp_du[m] = (d < 0) ? 0 : d;
                    exp_ds[m] = (d + 8192) % 8192;
                    sum_on[m] = 0; sum_off[m] = 0; n_on[m] = 0; n_off[m] = 0;
                end
            end
        end
    endfunction

    task automatic step(input bit sv, input bit ph, input int s, input bit clr);
        sample_valid = sv; phase = ph; sample = 12'(s); clear = clr;
        @(posedge clk);
        model_edge(sv, ph, s, clr);
        #1;
        sample_valid = 1'b0; clear = 1'b0;
        if (v0) pulses0++;
        if (v2) pulses2++;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if ({v0, on0, off0, d0, v1, on1, off1, d1, v2, on2, off2, d2} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b%b%b on=%0d off=%0d diff=%0d want all 0", v0, v1, v2, on0, off0, d0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step(0, 0, 0, 1);
        pulses0 = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, i < 5, (i < 5) ? 1000 : 200, 0);
            checks++;
            if ({v0, v1, v2} !== {exp_vld[0], exp_vld[0], exp_vld[1]}) begin
                failures++;
                $display("FAIL basic_vld step %0d got %b want %b", i, {v0, v1, v2}, {exp_vld[0], exp_vld[0], exp_vld[1]});
            end
            if (exp_vld[1]) begin
                checks++;
                if ({on2, off2, d2} !== {12'(exp_on[1]), 12'(exp_off[1]), 13'(exp_du[1])}) begin
                    failures++;
                    $display("FAIL basic_b0 got %0d/%0d/%0d want %0d/%0d/%0d", on2, off2, d2, exp_on[1], exp_off[1], exp_du[1]);
                end
            end
        end
        checks++;
        if ({v0, on0, off0, d0, pulses0} !== {1'b1, 12'd1000, 12'd200, 13'd800, 32'd1}) begin
            failures++;
            $display("FAIL basic_result got v=%b on=%0d off=%0d diff=%0d pulses=%0d want 1/1000/200/800/1", v0, on0, off0, d0, pulses0);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, i < 5, (i < 5) ? 100 : 300, 0);
        checks++;
        if ({v0, v1, on0, off0, d0, d1} !== {1'b1, 1'b1, 12'd100, 12'd300, 13'd0, 13'h1F38}) begin
            failures++;
            $display("FAIL underflow got v=%b%b on=%0d off=%0d diff_u=%h diff_s=%h want 11/100/300/0/1f38", v0, v1, on0, off0, d0, d1);
        end
    endtask

    task automatic test_avg_drop();
        int seq[12] = '{9, 1, 2, 3, 4, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
        step(0, 0, 0, 1);
        pulses0 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, i < 7, seq[i], 0);
            checks++;
            if ({v0, v2} !== {exp_vld[0], exp_vld[1]}) begin
                failures++;
                $display("FAIL avg_vld step %0d got %b%b want %b%b", i, v0, v2, exp_vld[0], exp_vld[1]);
            end
        end
        checks++;
        if ({v0, on0, off0, d0, d1, pulses0} !== {1'b1, 12'd2, 12'd4095, 13'd0, 13'h1003, 32'd1}) begin
            failures++;
            $display("FAIL avg_drop got v=%b on=%0d off=%0d du=%h ds=%h pulses=%0d want 1/2/4095/0/1003/1", v0, on0, off0, d0, d1, pulses0);
        end
        checks++;
        if ({on2, off2, d2} !== {12'(exp_on[1]), 12'(exp_off[1]), 13'(exp_du[1])}) begin
            failures++;
            $display("FAIL avg_b0 got %0d/%0d/%0d want %0d/%0d/%0d", on2, off2, d2, exp_on[1], exp_off[1], exp_du[1]);
        end
    endtask

    task automatic test_clear();
        step(0, 0, 0, 1);
        pulses0 = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 3000, 0);
        step(1, 1, 777, 1);
        step(1, 1, 3000, 0);
        checks++;
        if ({pulses0, sum_on[0], n_on[0]} !== {32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL clear_flush got pulses=%0d model_on=%0d/%0d want 0/0/0", pulses0, sum_on[0], n_on[0]);
        end
        for (int i = 0; i < 9; i++) begin
            step(1, i < 4, (i < 4) ? 50 : 10, 0);
            checks++;
            if ({v0, v2} !== {exp_vld[0], exp_vld[1]}) begin
                failures++;
                $display("FAIL clear_vld step %0d got %b%b want %b%b", i, v0, v2, exp_vld[0], exp_vld[1]);
            end
        end
        checks++;
        if ({v0, on0, off0, d0, pulses0} !== {1'b1, 12'd50, 12'd10, 13'd40, 32'd1}) begin
            failures++;
            $display("FAIL clear_result got v=%b on=%0d off=%0d diff=%0d pulses=%0d want 1/50/10/40/1", v0, on0, off0, d0, pulses0);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 1);
        pulses2 = 0;
        for (int i = 0; i < 64; i++) begin
            step(1, (i % 8) < 4, $urandom_range(0, 4095), 0);
            checks++;
            if ({v2, v0} !== {((i % 8) == 7), exp_vld[0]}) begin
                failures++;
                $display("FAIL b2b_vld step %0d got %b%b want %b%b", i, v2, v0, (i % 8) == 7, exp_vld[0]);
            end
            if (exp_vld[1]) begin
                checks++;
                if ({on2, off2, d2} !== {12'(exp_on[1]), 12'(exp_off[1]), 13'(exp_du[1])}) begin
                    failures++;
                    $display("FAIL b2b_data step %0d got %0d/%0d/%0d want %0d/%0d/%0d", i, on2, off2, d2, exp_on[1], exp_off[1], exp_du[1]);
                end
            end
        end
        checks++;
        if (pulses2 !== 8) begin
            failures++;
            $display("FAIL b2b_pulses got %0d want 8", pulses2);
        end
    endtask

    task automatic test_random();
        bit ph = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) ph = ~ph;
            step($urandom_range(0, 3) != 0, ph, $urandom_range(0, 4095), $urandom_range(0, 99) == 0);
            checks++;
            if ({v0, v1, v2} !== {exp_vld[0], exp_vld[0], exp_vld[1]}) begin
                failures++;
                $display("FAIL rand_vld step %0d got %b want %b", i, {v0, v1, v2}, {exp_vld[0], exp_vld[0], exp_vld[1]});
            end
            if (exp_vld[0]) begin
                checks++;
                if ({on0, off0, d0, d1} !== {12'(exp_on[0]), 12'(exp_off[0]), 13'(exp_du[0]), 13'(exp_ds[0])}) begin
                    failures++;
                    $display("FAIL rand_data0 step %0d got %0d/%0d/%h/%h want %0d/%0d/%h/%h", i, on0, off0, d0, d1, exp_on[0], exp_off[0], exp_du[0], exp_ds[0]);
                end
            end
            if (exp_vld[1]) begin
                checks++;
                if ({on2, off2, d2} !== {12'(exp_on[1]), 12'(exp_off[1]), 13'(exp_du[1])}) begin
                    failures++;
                    $display("FAIL rand_data2 step %0d got %0d/%0d/%0d want %0d/%0d/%0d", i, on2, off2, d2, exp_on[1], exp_off[1], exp_du[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 1, 2000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v0, on0, off0, d0, v1, on1, off1, d1, v2, on2, off2, d2} !== '0) begin
            failures++;
            $display("FAIL reset_mid got on=%0d off=%0d diff=%0d on_b0=%0d want all 0", on0, off0, d0, on2);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        pulses0 = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, i < 5, (i < 5) ? 700 + i : 300, 0);
            checks++;
            if ({v0, v2} !== {(i == 9), exp_vld[1]}) begin
                failures++;
                $display("FAIL reset_mid_vld step %0d got %b%b want %b%b", i, v0, v2, i == 9, exp_vld[1]);
            end
        end
        checks++;
        if ({on0, off0, d0, pulses0} !== {12'd702, 12'd300, 13'd402, 32'd1}) begin
            failures++;
            $display("FAIL reset_mid_result got on=%0d off=%0d diff=%0d pulses=%0d want 702/300/402/1", on0, off0, d0, pulses0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_avg_drop();
        test_clear();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lockin_demodulator.md
# lockin_demodulator

Parametrised synchronous (lock-in) demodulator between the XADC sample path and downstream readout. It splits ADC samples into PWM-on and PWM-off buckets and blanks settling samples after each PWM edge. Each bucket is averaged over 2^AVG_LOG2 samples, and the block emits on-minus-off as one result per window, with a valid strobe. The difference can be clamped (unsigned) or two's complement (signed).

## Interface
- DATA_W, 12, ADC sample width.
- AVG_LOG2, 4, log2 of samples averaged per bucket (N = 2^AVG_LOG2, 0..8).
- BLANK, 2, samples discarded after every phase change (0..15).
- SIGNED_OUT, 0, 0: out_diff = max(on-off, 0); 1: out_diff = on-off in two's complement.
- clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- sample_valid, input, 1, one-cycle strobe: sample and phase are valid this cycle.
- sample, input, DATA_W, ADC code (unsigned).
- phase, input, 1, PWM reference level, sampled only with sample_valid; 1 = on bucket.
- clear, input, 1, synchronous flush of accumulators, counters and blanking.
- out_valid, output, 1, one-cycle pulse: new result on outputs.
- out_on_avg, output, DATA_W, averaged on bucket.
- out_off_avg, output, DATA_W, averaged off bucket.
- out_diff, output, DATA_W+1, demodulated difference.

## Operation
- Registers:
  - on_acc and off_acc, each DATA_W+AVG_LOG2 bits.
  - on_cnt and off_cnt, each AVG_LOG2+1 bits.
  - last_phase.
  - first flag, set by reset.
  - blank_cnt, 4 bits.
- Per accepted sample_valid (clear low):
  - If first is set or phase != last_phase: load blank_cnt = BLANK, update last_phase, clear first.
  - Treat the sample with the newly loaded blank_cnt. If BLANK = 0 the sample is used; else it is discarded and blank_cnt decrements.
  - Otherwise, if blank_cnt > 0: discard the sample and decrement blank_cnt.
  - Otherwise, add the sample to the bucket selected by phase and increment that bucket's count, but only if its count < N.
  - Samples arriving for a full bucket are dropped.
- Completion: when the accepting sample makes both counts equal N, a result is produced:
  - out_on_avg = on_acc_total >> AVG_LOG2, truncated.
  - out_off_avg is computed the same way from off_acc_total.
  - out_diff uses these averages.
  - Accumulators and counts are zeroed in the same cycle. last_phase and blank_cnt are kept.
- Arithmetic: diff = {0,on_avg} - {0,off_avg} in DATA_W+1 bits.
  - SIGNED_OUT=0: a negative result (on < off) yields 0, zero-extended.
  - Accumulators cannot overflow; N·(2^DATA_W-1) fits DATA_W+AVG_LOG2 bits.
- clear: zeroes accumulators and counts and sets first.
  - A sample_valid in the same cycle is dropped (clear wins).
  - Output registers are not affected.
- out_on_avg, out_off_avg and out_diff hold their values until the next result.

## Timing
- Reset (rst_n low, asynchronous): all outputs 0, out_valid 0, accumulators and counts 0, first = 1, blank_cnt = 0.
  - Reset taken mid-window discards the partial window.
- Latency: out_valid goes high in the cycle after the clk edge that accepts the completing sample. Output values are valid in that same cycle. Pulse width is exactly 1 cycle.
- Throughput: sample_valid is accepted every cycle, back-to-back, with no backpressure.
- A new window starts accumulating on the cycle after completion.
- A sample arriving the cycle after completion is accepted normally.
- Phase changes while a bucket is full still trigger blanking.

## Test plan
All scenarios use DATA_W=12, AVG_LOG2=2 (N=4), BLANK=1 unless noted.

- Reset: hold rst_n low mid-run, asynchronously between edges -> out_valid, out_diff, out_on_avg and out_off_avg read 0 immediately. A subsequent window produces a result only after full blanking plus 4+4 samples.
- Basic demod:
  - Stimulus: phase=1 with 5 samples of 1000 (first blanked), then phase=0 with 5 samples of 200.
  - Required: a single out_valid pulse 1 cycle after the last accepted sample, with out_on_avg=1000, out_off_avg=200, out_diff=800.
- Underflow:
  - Stimulus: on samples 100, off samples 300.
  - Required: SIGNED_OUT=0 gives out_diff=0. SIGNED_OUT=1 gives out_diff=13'h1F38 (-200).
- Averaging, blanking and drops:
  - On samples 9 (blanked), 1, 2, 3, 4 give out_on_avg=2 (10>>2).
  - 2 extra on samples of 4095 after the bucket is full are dropped and do not alter the result.
  - An off bucket of 4095 ×4 gives out_off_avg=4095.
- Clear:
  - Assert clear after 2 accepted on samples, with sample_valid high in the same cycle.
  - Required: that sample is dropped, the next sample is blanked, no out_valid occurs, and the next full window yields only post-clear data.
- Back-to-back windows (BLANK=0): continuous alternating 4-on/4-off bursts every cycle -> out_valid every 8th cycle, with no sample lost at window boundaries.
